cla_cell: RTL and testbench
===========================

CLA_CELL -- requirements
Module: cla_cell

Interface
REQ-001 The block SHALL have parameter WIDTH, default 16, giving the operand and sum width in bits.
REQ-002 WIDTH SHALL be a multiple of 4 in the range 4..64; other values are unsupported and need not elaborate.
REQ-003 The block SHALL have port clk, input, 1 bit: the single clock; all state updates on its rising edge.
REQ-004 The block SHALL have port rst_n, input, 1 bit: reset, asynchronous and active-low.
REQ-005 The block SHALL have port a, input, WIDTH bits: addend A, unsigned.
REQ-006 The block SHALL have port b, input, WIDTH bits: addend B, unsigned.
REQ-007 The block SHALL have port cin, input, 1 bit: carry into bit 0.
REQ-008 The block SHALL have port s, output, WIDTH bits: registered sum, a+b+cin modulo 2^WIDTH.
REQ-009 The block SHALL have port cout, output, 1 bit: registered carry out of bit WIDTH-1.

Function
REQ-010 The block SHALL compute {cout,s} = a + b + cin exactly, as a (WIDTH+1)-bit unsigned result.
REQ-011 Per bit i, the block SHALL form generate g[i]=a[i]&b[i] and propagate p[i]=a[i]^b[i], with s[i]=p[i]^c[i] and c[0]=cin.
REQ-012 Carries SHALL be produced by 4-bit lookahead groups; each group computes its internal carries directly from g, p and the group carry-in, with no ripple.
REQ-013 Each group SHALL also produce group generate G and group propagate P.
REQ-014 Group carry-ins SHALL come from a second-level lookahead over the group G/P and cin, with one lookahead unit per 4 groups, and a third level if WIDTH exceeds 16.
REQ-015 A bit-serial ripple-carry chain across WIDTH SHALL NOT be used.
REQ-016 The adder core SHALL be purely combinational.
REQ-017 s and cout SHALL be registered on the rising edge of clk, giving a latency of exactly 1 clock from inputs to outputs.
REQ-018 The block SHALL accept a new operand set every cycle (throughput 1/cycle) with no handshake and no stall.
REQ-019 Outputs SHALL hold their value until the next rising clk edge.
REQ-020 Boundary: all-ones + all-ones + 1 SHALL give s = all-ones, cout = 1.
REQ-021 Boundary: all-ones + 0 + 1 SHALL give s = 0, cout = 1 (full carry propagation through every group).
REQ-022 Boundary: 0 + 0 + 0 SHALL give s = 0, cout = 0.
REQ-023 No latches SHALL be inferred.
REQ-024 The block SHALL have no X-propagation sources other than X inputs.

Reset
REQ-025 While rst_n = 0, s SHALL be 0 and cout SHALL be 0, asynchronously (without waiting for clk).
REQ-026 Reset assertion mid-operation SHALL immediately clear s and cout; the result for the cycle in flight is discarded.
REQ-027 After rst_n deasserts, the first rising clk edge SHALL capture the sum of the inputs present at that edge.
REQ-028 The adder core has no internal state; only the output registers are reset.

Verification
REQ-029 WIDTH=16: a=0x0000, b=0x0000, cin=0 -> s=0x0000, cout=0 one clock later.
REQ-030 WIDTH=16: a=0xFFFF, b=0x0001, cin=0 -> s=0x0000, cout=1 one clock later.
REQ-031 WIDTH=16: a=0xFFFF, b=0xFFFF, cin=1 -> s=0xFFFF, cout=1.
REQ-032 WIDTH=16: a=0x1234, b=0x4321, cin=1 -> s=0x5556, cout=0.
REQ-033 Back-to-back stream: 100 random {a,b,cin} vectors applied one per cycle -> each output equals the (WIDTH+1)-bit sum a+b+cin of the vector applied one cycle earlier, with zero mismatches.
REQ-034 Reset mid-stream: drive rst_n low between clk edges -> s=0 and cout=0 immediately; after release, the first edge yields the correct sum.

Source files
------------

// File: rtl/cla_cell.sv
// Registered two/three-level carry-lookahead adder: {cout,s} <= a + b + cin.
// 4-bit groups feed block lookahead units (4 groups each), and blocks feed a top unit when WIDTH > 16.
module cla_cell #(
  parameter int WIDTH = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  output logic [WIDTH-1:0] s,
  output logic             cout
);

  localparam int NG = WIDTH / 4;
  localparam int NB = (NG + 3) / 4;

  // Carry after n positions of a 4-wide lookahead unit, as a flat sum of products.
  function automatic logic lac(input logic [3:0] g, input logic [3:0] p,
                               input logic ci, input int unsigned n);
    logic c;
    logic t;
    c = ci;
    for (int unsigned k = 0; k < 4; k++) if (k < n) c = c & p[k];
    for (int unsigned j = 0; j < 4; j++) begin
      if (j < n) begin
        t = g[j];
        for (int unsigned k = j + 1; k < 4; k++) if (k < n) t = t & p[k];
        c = c | t;
      end
    end
    return c;
  endfunction

  logic [WIDTH-1:0]  w_g, w_p, w_c;
  logic [4*NB-1:0]   w_G, w_P;
  logic [NG-1:0]     w_gc;
  logic [NB-1:0]     w_bc;

  assign w_g = a & b;
  assign w_p = a ^ b;

  // Groups past NG are padded transparent (G=0, P=1) so block G/P stay exact.
  for (genvar k = 0; k < 4 * NB; k++) begin : g_grp
    if (k < NG) begin : g_real
      for (genvar m = 0; m < 4; m++) begin : g_bit
        if (m == 0) begin : g_c0
          assign w_c[4*k] = w_gc[k];
        end else begin : g_cm
          assign w_c[4*k+m] = lac(w_g[4*k +: 4], w_p[4*k +: 4], w_gc[k], m);
        end
      end
      assign w_G[k] = lac(w_g[4*k +: 4], w_p[4*k +: 4], 1'b0, 4);
      assign w_P[k] = &w_p[4*k +: 4];
    end else begin : g_pad
      assign w_G[k] = 1'b0;
      assign w_P[k] = 1'b1;
    end
  end

  for (genvar j = 0; j < NB; j++) begin : g_blk
    for (genvar m = 0; m < 4; m++) begin : g_gc
      if (4 * j + m < NG) begin : g_used
        if (m == 0) begin : g_c0
          assign w_gc[4*j] = w_bc[j];
        end else begin : g_cm
          assign w_gc[4*j+m] = lac(w_G[4*j +: 4], w_P[4*j +: 4], w_bc[j], m);
        end
      end
    end
  end

  if (NB == 1) begin : g_top1
    assign w_bc[0] = cin;
  end else begin : g_top
    logic [3:0] w_BG, w_BP;
    for (genvar j = 0; j < 4; j++) begin : g_bgp
      if (j < NB) begin : g_real
        assign w_BG[j] = lac(w_G[4*j +: 4], w_P[4*j +: 4], 1'b0, 4);
        assign w_BP[j] = &w_P[4*j +: 4];
      end else begin : g_pad
        assign w_BG[j] = 1'b0;
        assign w_BP[j] = 1'b1;
      end
    end
    for (genvar j = 0; j < NB; j++) begin : g_bc
      if (j == 0) begin : g_c0
        assign w_bc[0] = cin;
      end else begin : g_cj
        assign w_bc[j] = lac(w_BG, w_BP, cin, j);
      end
    end
  end

  logic w_cout;
  assign w_cout = lac(w_G[4*(NB-1) +: 4], w_P[4*(NB-1) +: 4], w_bc[NB-1], 4);

  logic [WIDTH-1:0] r_s;
  logic             r_cout;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_s    <= '0;
      r_cout <= 1'b0;
    end else begin
      r_s    <= w_p ^ w_c;
      r_cout <= w_cout;
    end
  end

  assign s    = r_s;
  assign cout = r_cout;

endmodule

// File: tb/tb_cla_cell.sv
// Directed-vector and random-stream bench for cla_cell at WIDTH=16.
module tb_cla_cell;

  localparam int W = 16;

  logic         clk = 1'b0;
  logic         rst_n;
  logic [W-1:0] a, b, s;
  logic         cin, cout;

  int n_cmp = 0;
  int n_bad = 0;

  cla_cell #(.WIDTH(W)) dut (
    .clk  (clk),
    .rst_n(rst_n),
    .a    (a),
    .b    (b),
    .cin  (cin),
    .s    (s),
    .cout (cout)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic         cin;
    logic [W-1:0] es;
    logic         ec;
  } vec_t;

  vec_t tbl[12];

  task automatic check(input string name, input logic [W-1:0] es, input logic ec);
    n_cmp++;
    if (s !== es || cout !== ec) begin
      n_bad++;
      $display("FAIL %s: got s=%h cout=%b, want s=%h cout=%b", name, s, cout, es, ec);
    end
  endtask

  task automatic drive(input logic [W-1:0] va, input logic [W-1:0] vb, input logic vc);
    a = va; b = vb; cin = vc;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  initial begin
    logic [W:0]   ref_sum;
    logic [W-1:0] ra, rb;
    logic         rc;

    tbl[0]  = '{16'h0000, 16'h0000, 1'b0, 16'h0000, 1'b0};
    tbl[1]  = '{16'hFFFF, 16'h0001, 1'b0, 16'h0000, 1'b1};
    tbl[2]  = '{16'hFFFF, 16'hFFFF, 1'b1, 16'hFFFF, 1'b1};
    tbl[3]  = '{16'h1234, 16'h4321, 1'b1, 16'h5556, 1'b0};
    tbl[4]  = '{16'hFFFF, 16'h0000, 1'b1, 16'h0000, 1'b1};
    tbl[5]  = '{16'h00FF, 16'h0001, 1'b0, 16'h0100, 1'b0};
    tbl[6]  = '{16'h8000, 16'h8000, 1'b0, 16'h0000, 1'b1};
    tbl[7]  = '{16'h0F0F, 16'hF0F0, 1'b1, 16'h0000, 1'b1};
    tbl[8]  = '{16'h7FFF, 16'h0001, 1'b0, 16'h8000, 1'b0};
    tbl[9]  = '{16'hABCD, 16'h1234, 1'b0, 16'hBE01, 1'b0};
    tbl[10] = '{16'hFFF0, 16'h000F, 1'b1, 16'h0000, 1'b1};
    tbl[11] = '{16'h0FFF, 16'h0000, 1'b1, 16'h1000, 1'b0};

    rst_n = 1'b0;
    drive(16'hFFFF, 16'hFFFF, 1'b1);
    #1 check("reset_async", 16'h0000, 1'b0);
    @(posedge clk); #1 check("reset_held", 16'h0000, 1'b0);
    @(negedge clk); rst_n = 1'b1;

    for (int i = 0; i < 12; i++) begin
      @(negedge clk);
      drive(tbl[i].a, tbl[i].b, tbl[i].cin);
      @(posedge clk); #1;
      check($sformatf("vec%0d", i), tbl[i].es, tbl[i].ec);
    end

    // Inputs change between edges; registered outputs must not move.
    @(negedge clk);
    drive(16'h0001, 16'h0001, 1'b0);
    #2 check("hold", tbl[11].es, tbl[11].ec);
    @(posedge clk); #1 check("hold_update", 16'h0002, 1'b0);

    for (int i = 0; i < 100; i++) begin
      @(negedge clk);
      ra = W'($urandom); rb = W'($urandom); rc = 1'($urandom);
      drive(ra, rb, rc);
      ref_sum = {1'b0, ra} + {1'b0, rb} + {{W{1'b0}}, rc};
      @(posedge clk); #1;
      check($sformatf("stream%0d", i), ref_sum[W-1:0], ref_sum[W]);
    end

    // Reset mid-operation, between edges.
    @(negedge clk);
    drive(16'hFFFF, 16'hFFFF, 1'b1);
    @(posedge clk); #1 check("pre_reset", 16'hFFFF, 1'b1);
    #2 rst_n = 1'b0;
    #1 check("midreset_async", 16'h0000, 1'b0);
    @(posedge clk); #1 check("midreset_held", 16'h0000, 1'b0);
    @(negedge clk);
    drive(16'h1234, 16'h4321, 1'b1);
    rst_n = 1'b1;
    #1 check("release_no_edge", 16'h0000, 1'b0);
    @(posedge clk); #1 check("first_after_reset", 16'h5556, 1'b0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
